// File: rtl/controlador_saida.sv
`default_nettype none
// ============================================================================
// Module      : controlador_saida
// Description : Vending-machine output controller. Carries out the price
//               comparator's decision: returns coins one at a time through
//               the ejector, or runs the product motor until the drop sensor
//               fires. Each wait for a sensor is bounded by a timeout that
//               traps the block in a sticky fault state. When an operation
//               finishes, it pulses concluido and limparMoedas together.
// Ports       : clk             - system clock, rising edge
//               reset           - asynchronous, active-low reset
//               valorMoedas     - accumulated coin value, latched on request
//               liberarProduto  - dispense command (rising edge = request)
//               devolverMoedas  - coin-return command (rising edge = request)
//               sensorMoeda     - ejector ack, one rising edge per coin
//               sensorProduto   - product-drop sensor, high = delivered
//               ejetarMoeda     - coin ejector drive
//               motorProduto    - product motor drive
//               moedasRestantes - coins still to return
//               ocupado         - operation in progress or fault
//               concluido       - one-cycle completion pulse
//               limparMoedas    - one-cycle accumulator clear pulse
//               erro            - sticky timeout fault
// Revision    : 1.0 - initial release
// ============================================================================
module controlador_saida #(
    parameter int LARGURA_PULSO  = 4,
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] valorMoedas,
    input  logic       liberarProduto,
    input  logic       devolverMoedas,
    input  logic       sensorMoeda,
    input  logic       sensorProduto,
    output logic       ejetarMoeda,
    output logic       motorProduto,
    output logic [3:0] moedasRestantes,
    output logic       ocupado,
    output logic       concluido,
    output logic       limparMoedas,
    output logic       erro
);

    localparam int c_PULSO_W = $clog2(LARGURA_PULSO + 1);
    localparam int c_TMO_W   = $clog2(TIMEOUT_CICLOS + 1);
    // Terminal counts: the counters start at 0 on state entry, so the last
    // cycle of a window is reached at value N-1.
    localparam logic [c_PULSO_W-1:0] c_PULSO_FIM = c_PULSO_W'(LARGURA_PULSO - 1);
    localparam logic [c_TMO_W-1:0]   c_TMO_FIM   = c_TMO_W'(TIMEOUT_CICLOS - 1);

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        DEVOLVENDO = 3'd1,
        ESPERA_ACK = 3'd2,
        LIBERANDO  = 3'd3,
        FIM        = 3'd4,
        ERRO       = 3'd5
    } estado_t;

    estado_t                estado_q, estado_d;
    logic                   lib_prev_q, dev_prev_q, sen_prev_q;
    logic [c_PULSO_W-1:0]   pulso_q, pulso_d;
    logic [c_TMO_W-1:0]     tmo_q, tmo_d;
    logic [3:0]             moedas_q, moedas_d;
    logic                   ejetar_q, motor_q, ocupado_q, concluido_q, erro_q;

    logic w_lib_req, w_dev_req, w_sen_req;

    assign w_lib_req = liberarProduto & ~lib_prev_q;
    assign w_dev_req = devolverMoedas & ~dev_prev_q;
    assign w_sen_req = sensorMoeda    & ~sen_prev_q;

    always_comb begin
        estado_d = estado_q;
        pulso_d  = pulso_q;
        tmo_d    = tmo_q;
        moedas_d = moedas_q;
        case (estado_q)
            OCIOSO: begin
                pulso_d = '0;
                tmo_d   = '0;
                // A simultaneous liberar edge is dropped: devolver has priority.
                if (w_dev_req) begin
                    moedas_d = valorMoedas;
                    estado_d = (valorMoedas == 4'd0) ? FIM : DEVOLVENDO;
                end else if (w_lib_req) begin
                    estado_d = LIBERANDO;
                end
            end
            DEVOLVENDO: begin
                if (pulso_q == c_PULSO_FIM) begin
                    pulso_d  = '0;
                    tmo_d    = '0;
                    estado_d = ESPERA_ACK;
                end else begin
                    pulso_d = pulso_q + c_PULSO_W'(1);
                end
            end
            ESPERA_ACK: begin
                // The ack is tested before the timeout so a same-cycle ack wins.
                if (w_sen_req) begin
                    if (moedas_q != 4'd0) begin
                        moedas_d = moedas_q - 4'd1;
                    end
                    pulso_d  = '0;
                    estado_d = (moedas_q <= 4'd1) ? FIM : DEVOLVENDO;
                end else if (tmo_q == c_TMO_FIM) begin
                    estado_d = ERRO;
                end else begin
                    tmo_d = tmo_q + c_TMO_W'(1);
                end
            end
            LIBERANDO: begin
                if (sensorProduto) begin
                    estado_d = FIM;
                end else if (tmo_q == c_TMO_FIM) begin
                    estado_d = ERRO;
                end else begin
                    tmo_d = tmo_q + c_TMO_W'(1);
                end
            end
            FIM:     estado_d = OCIOSO;
            ERRO:    estado_d = ERRO;
            default: estado_d = OCIOSO;
        endcase
    end

    // Outputs are decoded from the next state into flops, so each actuator
    // changes on the same edge as the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q    <= OCIOSO;
            lib_prev_q  <= 1'b0;
            dev_prev_q  <= 1'b0;
            sen_prev_q  <= 1'b0;
            pulso_q     <= '0;
            tmo_q       <= '0;
            moedas_q    <= 4'd0;
            ejetar_q    <= 1'b0;
            motor_q     <= 1'b0;
            ocupado_q   <= 1'b0;
            concluido_q <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            lib_prev_q  <= liberarProduto;
            dev_prev_q  <= devolverMoedas;
            sen_prev_q  <= sensorMoeda;
            pulso_q     <= pulso_d;
            tmo_q       <= tmo_d;
            moedas_q    <= moedas_d;
            ejetar_q    <= (estado_d == DEVOLVENDO);
            motor_q     <= (estado_d == LIBERANDO);
            ocupado_q   <= (estado_d != OCIOSO);
            concluido_q <= (estado_d == FIM);
            erro_q      <= (estado_d == ERRO);
        end
    end

    assign ejetarMoeda     = ejetar_q;
    assign motorProduto    = motor_q;
    assign moedasRestantes = moedas_q;
    assign ocupado         = ocupado_q;
    assign concluido       = concluido_q;
    assign limparMoedas    = concluido_q;
    assign erro            = erro_q;

endmodule
`default_nettype wire

// File: tb/tb_controlador_saida.sv
`default_nettype none
// ============================================================================
// Module      : tb_controlador_saida
// Description : Self-checking bench for controlador_saida. Each table record
//               is one complete operation with its sensor behaviour and the
//               hand-derived outcome (pulse count, actuator cycles, latency,
//               final coin count, fault). Records are pushed to a scoreboard
//               queue on stimulus and popped when the operation ends.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controlador_saida;

    localparam int LARGURA_PULSO  = 4;
    localparam int TIMEOUT_CICLOS = 16;
    localparam int c_BUDGET       = 200;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] valorMoedas;
    logic       liberarProduto, devolverMoedas, sensorMoeda, sensorProduto;
    logic       ejetarMoeda, motorProduto, ocupado, concluido, limparMoedas, erro;
    logic [3:0] moedasRestantes;

    controlador_saida #(
        .LARGURA_PULSO  (LARGURA_PULSO),
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .valorMoedas     (valorMoedas),
        .liberarProduto  (liberarProduto),
        .devolverMoedas  (devolverMoedas),
        .sensorMoeda     (sensorMoeda),
        .sensorProduto   (sensorProduto),
        .ejetarMoeda     (ejetarMoeda),
        .motorProduto    (motorProduto),
        .moedasRestantes (moedasRestantes),
        .ocupado         (ocupado),
        .concluido       (concluido),
        .limparMoedas    (limparMoedas),
        .erro            (erro)
    );

    always #5 clk = ~clk;

    // ack_d: cycles from ejector fall to raising sensorMoeda (-1 = never)
    // ack_w: cycles sensorMoeda stays high; prod_d: cycle sensorProduto rises
    typedef struct {
        bit         dev;
        bit         lib;
        logic [3:0] valor;
        int         ack_d;
        int         ack_w;
        int         prod_d;
        int         e_pulsos;
        int         e_ejcyc;
        int         e_motor;
        int         e_conc;
        bit         e_erro;
        int         e_rem;
        int         e_lat;
    } vec_t;

    typedef struct {
        int pulsos;
        int ejcyc;
        int motor;
        int conc;
        int erro;
        int rem;
        int rem1;
        int lat;
    } meas_t;

    vec_t vecs[11];
    vec_t sb[$];
    int   nvec  = 0;
    int   nfail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input vec_t v, output meas_t m);
        int  t, wcnt, hold;
        bit  ej_prev, done;
        m = '{default: 0};
        t = 0; wcnt = -1; hold = 0; ej_prev = 1'b0; done = 1'b0;
        valorMoedas    = v.valor;
        devolverMoedas = v.dev;
        liberarProduto = v.lib;
        while (!done && t < c_BUDGET) begin
            tick();
            t++;
            if (t == 1) m.rem1 = moedasRestantes;
            if (ejetarMoeda && !ej_prev) m.pulsos++;
            if (ejetarMoeda) m.ejcyc++;
            if (motorProduto) m.motor++;
            if (concluido !== limparMoedas) chk("conc_eq_limpar", limparMoedas, concluido);
            if (concluido) begin m.conc++; m.lat = t; done = 1'b1; end
            if (erro) begin m.erro = 1; m.lat = t; done = 1'b1; end
            // coin ejector acknowledge model
            if (hold > 0) begin
                hold--;
                if (hold == 0) sensorMoeda = 1'b0;
            end
            if (!ejetarMoeda && ej_prev) wcnt = 0;
            if (wcnt >= 0) begin
                if (v.ack_d >= 0 && wcnt == v.ack_d) begin
                    sensorMoeda = 1'b1;
                    hold = v.ack_w;
                    wcnt = -1;
                end else begin
                    wcnt++;
                end
            end
            if (v.lib && v.prod_d > 0 && t == v.prod_d) sensorProduto = 1'b1;
            ej_prev = ejetarMoeda;
        end
        if (!done) chk("op_timeout", t, -1);
        m.rem = moedasRestantes;
        devolverMoedas = 1'b0;
        liberarProduto = 1'b0;
        sensorMoeda    = 1'b0;
        sensorProduto  = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_ej"},   ejetarMoeda, 0);
        chk({nm, "_mot"},  motorProduto, 0);
        chk({nm, "_rem"},  moedasRestantes, 0);
        chk({nm, "_ocp"},  ocupado, 0);
        chk({nm, "_conc"}, concluido, 0);
        chk({nm, "_lim"},  limparMoedas, 0);
        chk({nm, "_erro"}, erro, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk_reset_outputs("reset");
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        meas_t m;
        vec_t  e;
        reset = 1'b1; valorMoedas = 4'd0; liberarProduto = 1'b0;
        devolverMoedas = 1'b0; sensorMoeda = 1'b0; sensorProduto = 1'b0;

        //          dev lib val ackd ackw prod  pul ejc mot conc err rem lat
        vecs[0]  = '{1, 0, 4'd3,  2,  1,  0,    3, 12,  0, 1, 0, 0, 22};
        vecs[1]  = '{0, 1, 4'd0, -1,  1, 10,    0,  0, 10, 1, 0, 0, 11};
        vecs[2]  = '{1, 0, 4'd0, -1,  1,  0,    0,  0,  0, 1, 0, 0,  1};
        vecs[3]  = '{1, 1, 4'd1,  2, 20,  0,    1,  4,  0, 1, 0, 0,  8};
        vecs[4]  = '{1, 0, 4'd1, 15,  1,  0,    1,  4,  0, 1, 0, 0, 21};
        vecs[5]  = '{1, 0, 4'd1, 16,  1,  0,    1,  4,  0, 0, 1, 1, 21};
        vecs[6]  = '{0, 1, 4'd0, -1,  1, 16,    0,  0, 16, 1, 0, 0, 17};
        vecs[7]  = '{0, 1, 4'd0, -1,  1, 17,    0,  0, 16, 0, 1, 0, 17};
        vecs[8]  = '{1, 0, 4'd2, -1,  1,  0,    1,  4,  0, 0, 1, 2, 21};
        vecs[9]  = '{1, 0, 4'd15, 0,  1,  0,   15, 60,  0, 1, 0, 0, 76};
        // a 20-cycle ack is a single edge: the second coin then times out
        vecs[10] = '{1, 0, 4'd2,  2, 20,  0,    2,  8,  0, 0, 1, 1, 28};

        #3;
        do_reset();

        for (int i = 0; i < 11; i++) begin
            sb.push_back(vecs[i]);
            run(vecs[i], m);
            e = sb.pop_front();
            chk($sformatf("v%0d_pulsos", i), m.pulsos, e.e_pulsos);
            chk($sformatf("v%0d_ejcyc", i),  m.ejcyc,  e.e_ejcyc);
            chk($sformatf("v%0d_motor", i),  m.motor,  e.e_motor);
            chk($sformatf("v%0d_conc", i),   m.conc,   e.e_conc);
            chk($sformatf("v%0d_erro", i),   m.erro,   int'(e.e_erro));
            chk($sformatf("v%0d_rem", i),    m.rem,    e.e_rem);
            chk($sformatf("v%0d_rem1", i),   m.rem1,   e.dev ? int'(e.valor) : 0);
            chk($sformatf("v%0d_lat", i),    m.lat,    e.e_lat);
            if (e.e_erro) begin
                // fault is sticky and new command edges are ignored
                tick();
                devolverMoedas = 1'b1;
                liberarProduto = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    chk($sformatf("v%0d_ign_ej", i),   ejetarMoeda, 0);
                    chk($sformatf("v%0d_ign_mot", i),  motorProduto, 0);
                    chk($sformatf("v%0d_ign_erro", i), erro, 1);
                    chk($sformatf("v%0d_ign_ocp", i),  ocupado, 1);
                    chk($sformatf("v%0d_ign_rem", i),  moedasRestantes, e.e_rem);
                end
                devolverMoedas = 1'b0;
                liberarProduto = 1'b0;
                do_reset();
            end else begin
                tick();
                chk($sformatf("v%0d_idle_ocp", i), ocupado, 0);
                chk($sformatf("v%0d_idle_conc", i), concluido, 0);
            end
        end

        // reset asserted while the ejector is driving
        valorMoedas    = 4'd5;
        devolverMoedas = 1'b1;
        tick();
        tick();
        chk("mid_ej_before", ejetarMoeda, 1);
        chk("mid_rem_before", moedasRestantes, 5);
        reset = 1'b0;
        #1;
        chk("mid_ej", ejetarMoeda, 0);
        chk("mid_ocp", ocupado, 0);
        chk("mid_rem", moedasRestantes, 0);
        tick();
        devolverMoedas = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid_after_conc", concluido, 0);
            chk("mid_after_ocp", ocupado, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
